id_ex_stage: RTL and testbench

Decode-to-execute pipeline register that feeds the ALU. It registers decoded operands, immediate, ALU opcode and destination info, and uses a valid/ready handshake for backpressure. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It then presents the final ALU operands (a, b) and a 4-bit alu_op to the ALU that sits directly downstream.

---
 rtl/id_ex_stage_if.sv | 55 +++++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decode-side instruction, forwarding taps and the
// registered ALU-facing outputs. master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [RA_W-1:0] in_rs1;
   logic [RA_W-1:0] in_rs2;
   logic [XLEN-1:0] in_rs1_data;
   logic [XLEN-1:0] in_rs2_data;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic            in_use_pc;
   logic [3:0]      in_alu_op;
   logic [RA_W-1:0] in_rd;
   logic            in_reg_write;

   logic            mem_fwd_we;
   logic [RA_W-1:0] mem_fwd_rd;
   logic [XLEN-1:0] mem_fwd_data;
   logic            wb_fwd_we;
   logic [RA_W-1:0] wb_fwd_rd;
   logic [XLEN-1:0] wb_fwd_data;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_op;
   logic [RA_W-1:0] out_rd;
   logic            out_reg_write;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_rs2_fwd;

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
             in_use_imm, in_use_pc, in_alu_op, in_rd, in_reg_write,
             mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
             out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_reg_write,
             out_pc, out_rs2_fwd
   );

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
             in_use_imm, in_use_pc, in_alu_op, in_rd, in_reg_write,
             mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
             out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_op, out_rd, out_reg_write,
             out_pc, out_rs2_fwd
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready backpressure, EX/MEM and MEM/WB operand
// forwarding, and final ALU operand selection.
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   id_ex_stage_if.slave  bus
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic            use_imm;
      logic            use_pc;
      logic [3:0]      alu_op;
      logic [RA_W-1:0] rd;
      logic            reg_write;
   } fields_t;

   fields_t         fields_q, fields_d;
   logic            valid_q, valid_d;
   logic            in_ready;
   logic            accept;
   logic            hold;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready && !flush;
   assign hold     = valid_q && !bus.out_ready;

   always_comb begin
      fields_d = fields_q;
      valid_d  = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d            = 1'b1;
         fields_d.pc        = bus.in_pc;
         fields_d.rs1       = bus.in_rs1;
         fields_d.rs2       = bus.in_rs2;
         fields_d.rs1_data  = bus.in_rs1_data;
         fields_d.rs2_data  = bus.in_rs2_data;
         fields_d.imm       = bus.in_imm;
         fields_d.use_imm   = bus.in_use_imm;
         fields_d.use_pc    = bus.in_use_pc;
         fields_d.alu_op    = bus.in_alu_op;
         fields_d.rd        = bus.in_rd;
         fields_d.reg_write = bus.in_reg_write;
      end else if (valid_q && bus.out_ready) begin
         valid_d = 1'b0;
      end
      // A value retiring through WB while stalled would otherwise be lost once it leaves the bypass.
      if (hold && bus.wb_fwd_we) begin
         if (fields_q.rs1 != '0 && bus.wb_fwd_rd == fields_q.rs1) fields_d.rs1_data = bus.wb_fwd_data;
         if (fields_q.rs2 != '0 && bus.wb_fwd_rd == fields_q.rs2) fields_d.rs2_data = bus.wb_fwd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         fields_q <= '0;
      end else begin
         valid_q  <= valid_d;
         fields_q <= fields_d;
      end
   end

   always_comb begin
      fwd_rs1 = fields_q.rs1_data;
      if (fields_q.rs1 != '0) begin
         if (bus.mem_fwd_we && bus.mem_fwd_rd == fields_q.rs1)     fwd_rs1 = bus.mem_fwd_data;
         else if (bus.wb_fwd_we && bus.wb_fwd_rd == fields_q.rs1)  fwd_rs1 = bus.wb_fwd_data;
      end
      fwd_rs2 = fields_q.rs2_data;
      if (fields_q.rs2 != '0) begin
         if (bus.mem_fwd_we && bus.mem_fwd_rd == fields_q.rs2)     fwd_rs2 = bus.mem_fwd_data;
         else if (bus.wb_fwd_we && bus.wb_fwd_rd == fields_q.rs2)  fwd_rs2 = bus.wb_fwd_data;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = valid_q;
   assign bus.alu_a         = fields_q.use_pc  ? fields_q.pc  : fwd_rs1;
   assign bus.alu_b         = fields_q.use_imm ? fields_q.imm : fwd_rs2;
   assign bus.alu_op        = fields_q.alu_op;
   assign bus.out_rd        = fields_q.rd;
   assign bus.out_reg_write = fields_q.reg_write && valid_q;
   assign bus.out_pc        = fields_q.pc;
   assign bus.out_rs2_fwd   = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: handshake, forwarding priority,
// stall-time WB capture, throughput, flush and asynchronous reset.
module tb_id_ex_stage;

   logic clk;
   logic rst_n;
   logic flush;
   int   pass_cnt;
   int   total_cnt;

   id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

   id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.in_valid     = 1'b0;
      bus.in_pc        = '0;
      bus.in_rs1       = '0;
      bus.in_rs2       = '0;
      bus.in_rs1_data  = '0;
      bus.in_rs2_data  = '0;
      bus.in_imm       = '0;
      bus.in_use_imm   = 1'b0;
      bus.in_use_pc    = 1'b0;
      bus.in_alu_op    = '0;
      bus.in_rd        = '0;
      bus.in_reg_write = 1'b0;
      bus.mem_fwd_we   = 1'b0;
      bus.mem_fwd_rd   = '0;
      bus.mem_fwd_data = '0;
      bus.wb_fwd_we    = 1'b0;
      bus.wb_fwd_rd    = '0;
      bus.wb_fwd_data  = '0;
      bus.out_ready    = 1'b1;
   endtask

   task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                              input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                              input logic use_imm, input logic use_pc, input logic [3:0] op,
                              input logic [4:0] rd, input logic rw);
      bus.in_valid     = 1'b1;
      bus.in_pc        = pc;
      bus.in_rs1       = rs1;
      bus.in_rs1_data  = d1;
      bus.in_rs2       = rs2;
      bus.in_rs2_data  = d2;
      bus.in_imm       = imm;
      bus.in_use_imm   = use_imm;
      bus.in_use_pc    = use_pc;
      bus.in_alu_op    = op;
      bus.in_rd        = rd;
      bus.in_reg_write = rw;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.alu_op !== 4'h0) $display("FAIL reset_alu_op: got %h want 0", bus.alu_op); else pass_cnt++;
      total_cnt++; if (bus.out_rd !== 5'd0) $display("FAIL reset_out_rd: got %0d want 0", bus.out_rd); else pass_cnt++;
      total_cnt++; if (bus.out_reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", bus.out_reg_write); else pass_cnt++;
      total_cnt++; if (bus.out_pc !== 32'h0) $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); else pass_cnt++;
      total_cnt++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0) $display("FAIL reset_alu_ab: got %h/%h want 0/0", bus.alu_a, bus.alu_b); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_basic_accept();
      @(negedge clk);
      drive_instr(32'h100, 5'd3, 32'd10, 5'd4, 32'd5, 32'h0, 1'b0, 1'b0, 4'b0001, 5'd9, 1'b1);
      bus.out_ready = 1'b1;
      #1;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL accept_latency: got out_valid %b want 0 before edge", bus.out_valid); else pass_cnt++;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL accept_out_valid: got %b want 1", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.alu_a !== 32'd10) $display("FAIL accept_alu_a: got %0d want 10", bus.alu_a); else pass_cnt++;
      total_cnt++; if (bus.alu_b !== 32'd5) $display("FAIL accept_alu_b: got %0d want 5", bus.alu_b); else pass_cnt++;
      total_cnt++; if (bus.alu_op !== 4'b0001) $display("FAIL accept_alu_op: got %b want 0001", bus.alu_op); else pass_cnt++;
      total_cnt++; if (bus.out_rd !== 5'd9 || bus.out_pc !== 32'h100) $display("FAIL accept_rd_pc: got %0d/%h want 9/100", bus.out_rd, bus.out_pc); else pass_cnt++;
      total_cnt++; if (bus.out_reg_write !== 1'b1) $display("FAIL accept_reg_write: got %b want 1", bus.out_reg_write); else pass_cnt++;
      #1;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
   endtask

   task automatic test_fwd_priority();
      // Instruction from test_basic_accept is held (rs1=3, rs2=4)
      bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 5'd3; bus.mem_fwd_data = 32'h77;
      bus.wb_fwd_we  = 1'b1; bus.wb_fwd_rd  = 5'd3; bus.wb_fwd_data  = 32'h55;
      #1;
      total_cnt++; if (bus.alu_a !== 32'h77) $display("FAIL fwd_mem_wins: got %h want 77", bus.alu_a); else pass_cnt++;
      total_cnt++; if (bus.out_rs2_fwd !== 32'd5) $display("FAIL fwd_rs2_nomatch: got %h want 5", bus.out_rs2_fwd); else pass_cnt++;
      bus.mem_fwd_we = 1'b0;
      #1;
      total_cnt++; if (bus.alu_a !== 32'h55) $display("FAIL fwd_wb_only: got %h want 55", bus.alu_a); else pass_cnt++;
      bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 5'd4; bus.mem_fwd_data = 32'h99;
      bus.wb_fwd_we  = 1'b0;
      #1;
      total_cnt++; if (bus.alu_b !== 32'h99 || bus.out_rs2_fwd !== 32'h99) $display("FAIL fwd_mem_rs2: got %h/%h want 99/99", bus.alu_b, bus.out_rs2_fwd); else pass_cnt++;
      total_cnt++; if (bus.alu_a !== 32'd10) $display("FAIL fwd_rs1_stored: got %h want a", bus.alu_a); else pass_cnt++;
      bus.mem_fwd_we = 1'b0;
      bus.out_ready  = 1'b1;
      @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0) $display("FAIL consume_empty: got v=%b rw=%b want 0/0", bus.out_valid, bus.out_reg_write); else pass_cnt++;
   endtask

   task automatic test_x0_and_select();
      drive_instr(32'h200, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0010, 5'd1, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 5'd0; bus.mem_fwd_data = 32'hFF;
      bus.wb_fwd_we  = 1'b1; bus.wb_fwd_rd  = 5'd0; bus.wb_fwd_data  = 32'hEE;
      #1;
      total_cnt++; if (bus.alu_a !== 32'h0) $display("FAIL x0_rs1_noforward: got %h want 0", bus.alu_a); else pass_cnt++;
      total_cnt++; if (bus.out_rs2_fwd !== 32'h0) $display("FAIL x0_rs2_noforward: got %h want 0", bus.out_rs2_fwd); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.alu_a !== 32'h0) $display("FAIL x0_no_capture: got %h want 0", bus.alu_a); else pass_cnt++;
      clear_inputs();
      drive_instr(32'h300, 5'd6, 32'h1234, 5'd8, 32'h5678, 32'h44, 1'b1, 1'b1, 4'b0000, 5'd2, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      total_cnt++; if (bus.alu_a !== 32'h300) $display("FAIL sel_pc: got %h want 300", bus.alu_a); else pass_cnt++;
      total_cnt++; if (bus.alu_b !== 32'h44) $display("FAIL sel_imm: got %h want 44", bus.alu_b); else pass_cnt++;
      total_cnt++; if (bus.out_rs2_fwd !== 32'h5678) $display("FAIL sel_store_data: got %h want 5678", bus.out_rs2_fwd); else pass_cnt++;
      total_cnt++; if (bus.out_reg_write !== 1'b0) $display("FAIL sel_reg_write: got %b want 0", bus.out_reg_write); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_hold_wb_capture();
      drive_instr(32'h400, 5'd1, 32'd2, 5'd7, 32'h1111, 32'h0, 1'b0, 1'b0, 4'b0011, 5'd12, 1'b1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      // A different instruction waits at the input for the whole stall
      drive_instr(32'h500, 5'd9, 32'h9, 5'd10, 32'hA, 32'h0, 1'b0, 1'b0, 4'b0100, 5'd13, 1'b1);
      bus.out_ready = 1'b0;
      bus.wb_fwd_we = 1'b1; bus.wb_fwd_rd = 5'd7; bus.wb_fwd_data = 32'hABCD;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready_%0d: got %b want 0", i, bus.in_ready); else pass_cnt++;
         @(negedge clk);
         bus.wb_fwd_we = 1'b0;
      end
      bus.in_valid = 1'b0;
      #1;
      total_cnt++; if (bus.alu_b !== 32'hABCD) $display("FAIL hold_wb_captured: got %h want abcd", bus.alu_b); else pass_cnt++;
      total_cnt++; if (bus.alu_a !== 32'd2 || bus.out_pc !== 32'h400) $display("FAIL hold_fields_kept: got %h/%h want 2/400", bus.alu_a, bus.out_pc); else pass_cnt++;
      bus.out_ready = 1'b1;
      @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL hold_release: got %b want 0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) begin
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1000 + 32'(4 * (i - 1)) || bus.alu_a !== 32'(100 + i - 1))
               $display("FAIL b2b_%0d: got v=%b pc=%h a=%0d want 1/%h/%0d", i - 1, bus.out_valid, bus.out_pc, bus.alu_a,
                        32'h1000 + 32'(4 * (i - 1)), 100 + i - 1);
            else pass_cnt++;
         end
         if (i < 4) drive_instr(32'h1000 + 32'(4 * i), 5'd5, 32'(100 + i), 5'd6, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0101, 5'd3, 1'b1);
         else bus.in_valid = 1'b0;
         #1;
         total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready_%0d: got %b want 1", i, bus.in_ready); else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_flush_and_reset();
      drive_instr(32'h600, 5'd2, 32'h20, 5'd3, 32'h30, 32'h0, 1'b0, 1'b0, 4'b0110, 5'd4, 1'b1);
      @(negedge clk);
      flush = 1'b1;
      drive_instr(32'h700, 5'd2, 32'h21, 5'd3, 32'h31, 32'h0, 1'b0, 1'b0, 4'b0111, 5'd5, 1'b1);
      #1;
      total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
      @(negedge clk);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0) $display("FAIL flush_squash: got v=%b rw=%b want 0/0", bus.out_valid, bus.out_reg_write); else pass_cnt++;
      drive_instr(32'h800, 5'd2, 32'h22, 5'd3, 32'h32, 32'h0, 1'b0, 1'b0, 4'b1001, 5'd6, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.alu_op !== 4'b1001) $display("FAIL prereset_hold: got v=%b op=%b want 1/1001", bus.out_valid, bus.alu_op); else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.alu_op !== 4'h0) $display("FAIL async_reset: got v=%b pc=%h op=%h want 0/0/0", bus.out_valid, bus.out_pc, bus.alu_op); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL post_reset_empty: got %b want 0", bus.out_valid); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_basic_accept();
      test_fwd_priority();
      test_x0_and_select();
      test_hold_wb_capture();
      test_back_to_back();
      test_flush_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
